norm_shift_enc: RTL and testbench

- Normalizes the raw mantissa sum from the FP adder datapath and produces the 9-bit shift code consumed by the exponent-adjust stage.
- Code format, producer side:
  - bit8 = 1: exponent decrement by [7:0].
  - bit8 = 0, nonzero [7:0]: increment.
  - 9'h000: already normalized.
  - [7:0] = 8'hff: zero result, forces exponent to 0.
- Iterative: one left-shift per clock, valid/ready handshake on both sides.
- Sits between the mantissa add/sub stage and the exponent-adjust stage.

---
 rtl/fp_add_pkg.sv | 16 +
 rtl/norm_shift_enc.sv | 121 ++++++++++++
 tb/tb_norm_shift_enc.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fp_add_pkg.sv
// Constants shared across the FP adder datapath: shift-code values, mantissa
// width and the control FSM encoding used by the normalizer and adder control.
package fp_add_pkg;

  localparam int unsigned MANT_W = 24;

  localparam logic [8:0] VAL2_ZERO = 9'h0ff;
  localparam logic [8:0] VAL2_NORM = 9'h000;
  localparam logic [8:0] VAL2_INC1 = 9'h001;
  localparam int unsigned VAL2_DEC_BIT = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/norm_shift_enc.sv
// Normalizes the raw mantissa sum one left-shift per clock and emits the
// shift code consumed by the exponent-adjust stage.
module norm_shift_enc #(
  parameter int unsigned MANT_W = fp_add_pkg::MANT_W,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W:0]   mant_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mant_out,
  output logic [CNT_W:0]    val2,
  output logic              lost_bit
);
  import fp_add_pkg::*;

  localparam int unsigned VW = CNT_W + 1;

  // The all-ones count is reserved for the zero code, so a real shift must stay below it.
  if ((MANT_W - 1 >= (2 ** CNT_W) - 1) || (VAL2_DEC_BIT != CNT_W)) begin : g_bad_params
    $error("norm_shift_enc: CNT_W too small for MANT_W or code width mismatch");
  end

  logic [1:0]        state_q, state_d;
  logic [MANT_W-1:0] work_q, work_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [CNT_W:0]    val2_q, val2_d;
  logic              lost_q, lost_d;

  logic [MANT_W-1:0] shifted;
  logic [CNT_W-1:0]  cnt_inc;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    mant_d  = mant_q;
    val2_d  = val2_q;
    lost_d  = lost_q;
    shifted = {work_q[MANT_W-2:0], 1'b0};
    cnt_inc = cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d = mant_in[MANT_W-1:0];
          cnt_d  = '0;
          if (mant_in == '0) begin
            state_d = ST_DONE;
            mant_d  = '0;
            val2_d  = VW'(VAL2_ZERO);
            lost_d  = 1'b0;
          end else if (mant_in[MANT_W]) begin
            state_d = ST_DONE;
            mant_d  = mant_in[MANT_W:1];
            val2_d  = VW'(VAL2_INC1);
            lost_d  = mant_in[0];
          end else if (mant_in[MANT_W-1]) begin
            state_d = ST_DONE;
            mant_d  = mant_in[MANT_W-1:0];
            val2_d  = VW'(VAL2_NORM);
            lost_d  = 1'b0;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_inc;
        // Outputs are only loaded once normalized, so no partial result is visible.
        if (shifted[MANT_W-1]) begin
          state_d = ST_DONE;
          mant_d  = shifted;
          val2_d  = {1'b1, cnt_inc};
          lost_d  = 1'b0;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      mant_q  <= '0;
      val2_q  <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mant_q  <= mant_d;
      val2_q  <= val2_d;
      lost_q  <= lost_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign mant_out  = mant_q;
  assign val2      = val2_q;
  assign lost_bit  = lost_q;

endmodule

// File: tb/tb_norm_shift_enc.sv
// Self-checking bench for norm_shift_enc: directed vector table, randomized
// inputs against a reference model, handshake stall and mid-shift reset.
module tb_norm_shift_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] mant_in;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] mant_out;
  logic [8:0]  val2;
  logic        lost_bit;

  int n_tests = 0;
  int n_fail  = 0;

  norm_shift_enc #(
    .MANT_W(24),
    .CNT_W (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mant_in  (mant_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mant_out (mant_out),
    .val2     (val2),
    .lost_bit (lost_bit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] m;
    logic [23:0] mo;
    logic [8:0]  v;
    logic        lb;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: zero / carry / normalized, else shift left until the MSB is set.
  function automatic void ref_model(input logic [24:0] m, output logic [23:0] mo,
                                    output logic [8:0] v, output logic lb, output int lat);
    int p;
    int n;
    lb = 1'b0;
    if (m == 25'd0) begin
      mo = 24'd0; v = 9'h0ff; lat = 1;
    end else if (m[24]) begin
      mo = m[24:1]; v = 9'h001; lb = m[0]; lat = 1;
    end else begin
      p = 23;
      while (!m[p]) p--;
      n   = 23 - p;
      mo  = 24'(m << n);
      v   = (n == 0) ? 9'h000 : (9'h100 + 9'(n));
      lat = n + 1;
    end
  endfunction

  task automatic send_wait(input logic [24:0] m, output int lat);
    @(negedge clk);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    mant_in  = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("out_valid_reached", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_dropped", {31'd0, out_valid}, 32'd0);
    check("in_ready_back", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [24:0] m, input logic [23:0] emo,
                        input logic [8:0] ev, input logic el, input int elat);
    int lat;
    send_wait(m, lat);
    check({tag, " latency"}, lat, elat);
    check({tag, " mant_out"}, {8'd0, mant_out}, {8'd0, emo});
    check({tag, " val2"}, {23'd0, val2}, {23'd0, ev});
    check({tag, " lost_bit"}, {31'd0, lost_bit}, {31'd0, el});
    release_out();
  endtask

  initial begin
    logic [23:0] emo;
    logic [8:0]  ev;
    logic        el;
    int          elat;
    logic [24:0] m;
    int          lat;

    vecs[0] = '{25'h0800000, 24'h800000, 9'h000, 1'b0, 1};
    vecs[1] = '{25'h1800001, 24'hc00000, 9'h001, 1'b1, 1};
    vecs[2] = '{25'h0000000, 24'h000000, 9'h0ff, 1'b0, 1};
    vecs[3] = '{25'h0000001, 24'h800000, 9'h117, 1'b0, 24};
    vecs[4] = '{25'h0400000, 24'h800000, 9'h101, 1'b0, 2};
    vecs[5] = '{25'h1ffffff, 24'hffffff, 9'h001, 1'b1, 1};
    vecs[6] = '{25'h0000003, 24'hc00000, 9'h116, 1'b0, 23};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mant_in   = '0;
    #2;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset mant_out", {8'd0, mant_out}, 32'd0);
    check("reset val2", {23'd0, val2}, 32'd0);
    check("reset lost_bit", {31'd0, lost_bit}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].mo, vecs[i].v, vecs[i].lb, vecs[i].lat);
    end

    for (int i = 0; i < 40; i++) begin
      m = 25'($urandom) >> $urandom_range(0, 26);
      if (i % 8 == 3) m[24] = 1'b1;
      ref_model(m, emo, ev, el, elat);
      run_op($sformatf("rnd%0d m=%h", i, m), m, emo, ev, el, elat);
    end

    // Stall: result must hold while out_ready is low, and new inputs are ignored.
    send_wait(25'h0400000, lat);
    check("stall latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      mant_in  = 25'h0000000;
      @(posedge clk);
      #1;
      check("stall out_valid", {31'd0, out_valid}, 32'd1);
      check("stall in_ready", {31'd0, in_ready}, 32'd0);
      check("stall mant_out", {8'd0, mant_out}, 32'h00800000);
      check("stall val2", {23'd0, val2}, 32'h101);
      check("stall lost_bit", {31'd0, lost_bit}, 32'd0);
    end
    in_valid = 1'b0;
    release_out();
    run_op("post_stall", 25'h1800001, 24'hc00000, 9'h001, 1'b1, 1);

    // Reset three cycles into a 19-step shift.
    @(negedge clk);
    in_valid = 1'b1;
    mant_in  = 25'h0000010;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_shift out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst mant_out", {8'd0, mant_out}, 32'd0);
    check("mid_rst val2", {23'd0, val2}, 32'd0);
    check("mid_rst lost_bit", {31'd0, lost_bit}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 25'h0000010, 24'h800000, 9'h113, 1'b0, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
